// File: rtl/bram_loader_arbiter_pkg.sv
// Shared memory geometry and loader FSM state encodings, also used by the core and the top level.
package bram_loader_arbiter_pkg;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 32;

    localparam logic [2:0] S_LEN0    = 3'd0;
    localparam logic [2:0] S_LEN1    = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_RUN     = 3'd4;

endpackage

// File: rtl/bram_loader_arbiter_word_assembler.sv
// Collects four little-endian bytes into a 32-bit word; word_valid flags the byte that completes it.
module word_assembler
    import bram_loader_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clear,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  word_valid,
    output logic [MEM_DATA_W-1:0] word
);

    logic [23:0] buffer;
    logic [1:0]  byte_idx;

    // The completing byte bypasses the buffer so the word is ready on the same edge it arrives.
    assign word_valid = byte_valid && (byte_idx == 2'd3);
    assign word       = {byte_data, buffer};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            buffer   <= '0;
            byte_idx <= '0;
        end else if (byte_valid) begin
            buffer   <= {byte_data, buffer[23:8]};
            byte_idx <= byte_idx + 2'd1;
        end
    end

endmodule

// File: rtl/bram_loader_arbiter.sv
// Shares the single BRAM port between the UART image loader and the core, holding the core in reset while loading.
module bram_loader_arbiter
    import bram_loader_arbiter_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  reload,
    input  logic                  core_memwe,
    input  logic [ADDR_W-1:0]     core_memaddr,
    input  logic [MEM_DATA_W-1:0] core_memdin,
    output logic                  memwe,
    output logic [ADDR_W-1:0]     memaddr,
    output logic [MEM_DATA_W-1:0] memdin,
    output logic                  core_rstn,
    output logic                  loading,
    output logic [ADDR_W:0]       loaded_words
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [2:0]            state;
    logic                  ld_we;
    logic [ADDR_W-1:0]     ld_addr;
    logic [MEM_DATA_W-1:0] ld_data;
    logic [15:0]           len;
    logic [15:0]           word_idx;
    logic                  byte_valid;
    logic                  word_valid;
    logic [MEM_DATA_W-1:0] word;

    // reload wins over a simultaneous byte, so that byte never reaches the assembler.
    assign byte_valid = rx_valid && (state == S_DATA) && !reload;

    word_assembler u_word_assembler (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (reload),
        .byte_valid (byte_valid),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= S_LEN0;
            core_rstn    <= 1'b0;
            ld_we        <= 1'b0;
            ld_addr      <= '0;
            ld_data      <= '0;
            len          <= '0;
            word_idx     <= '0;
            loaded_words <= '0;
        end else if (reload) begin
            state        <= S_LEN0;
            core_rstn    <= 1'b0;
            ld_we        <= 1'b0;
            word_idx     <= '0;
            loaded_words <= '0;
        end else begin
            ld_we <= 1'b0;
            case (state)
                S_LEN0: begin
                    if (rx_valid) begin
                        len[7:0] <= rx_data;
                        state    <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (rx_valid) begin
                        len[15:8] <= rx_data;
                        state     <= ({rx_data, len[7:0]} == 16'd0) ? S_RELEASE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (word_valid) begin
                        ld_data <= word;
                        ld_addr <= word_idx[ADDR_W-1:0];
                        // Words past the end of the BRAM are consumed but never written; no wrap.
                        if (32'(word_idx) < DEPTH) begin
                            ld_we        <= 1'b1;
                            loaded_words <= loaded_words + (ADDR_W+1)'(1);
                        end
                        word_idx <= word_idx + 16'd1;
                        if (word_idx == len - 16'd1) begin
                            state <= S_RELEASE;
                        end
                    end
                end
                S_RELEASE: begin
                    state     <= S_RUN;
                    core_rstn <= 1'b1;
                end
                S_RUN: begin
                    state <= S_RUN;
                end
                default: begin
                    state <= S_LEN0;
                end
            endcase
        end
    end

    assign loading = (state != S_RUN);

    // NOTE: every output gets a value on every path through always_comb, so no latch can be inferred.
    always_comb begin
        if (state == S_RUN) begin
            memwe   = core_memwe;
            memaddr = core_memaddr;
            memdin  = core_memdin;
        end else begin
            memwe   = ld_we;
            memaddr = ld_addr;
            memdin  = ld_data;
        end
    end

endmodule

// File: tb/tb_bram_loader_arbiter.sv
// Randomized bench: images are decoded by a byte-level model and compared with the writes seen on the BRAM port.
module tb_bram_loader_arbiter;

    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rstn;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          reload;
    logic          core_memwe;
    logic [AW-1:0] core_memaddr;
    logic [31:0]   core_memdin;
    logic          memwe;
    logic [AW-1:0] memaddr;
    logic [31:0]   memdin;
    logic          core_rstn;
    logic          loading;
    logic [AW:0]   loaded_words;

    logic [7:0]    img[$];
    logic [39:0]   exp_q[$];
    logic [39:0]   obs_q[$];
    int            n_vec = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    bram_loader_arbiter #(.ADDR_W(AW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .reload       (reload),
        .core_memwe   (core_memwe),
        .core_memaddr (core_memaddr),
        .core_memdin  (core_memdin),
        .memwe        (memwe),
        .memaddr      (memaddr),
        .memdin       (memdin),
        .core_rstn    (core_rstn),
        .loading      (loading),
        .loaded_words (loaded_words)
    );

    // Every BRAM write made while the loader owns the port.
    always @(negedge clk) begin
        if (rstn && memwe && loading) obs_q.push_back({memaddr, memdin});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_core();
        core_memwe   = 1'($urandom);
        core_memaddr = 8'($urandom);
        core_memdin  = $urandom;
    endtask

    task automatic begin_image(input int n);
        img.delete();
        img.push_back(8'(n));
        img.push_back(8'(n >> 8));
    endtask

    task automatic add_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) img.push_back(w[8*b +: 8]);
    endtask

    // Decodes the image straight from its byte format: word w lands at address w if it fits.
    task automatic model_image(output int loaded);
        int n;
        n = int'({img[1], img[0]});
        exp_q.delete();
        for (int w = 0; w < n; w++) begin
            if (w < DEPTH)
                exp_q.push_back({8'(w), img[2+4*w+3], img[2+4*w+2], img[2+4*w+1], img[2+4*w]});
        end
        loaded = (n < DEPTH) ? n : DEPTH;
    endtask

    task automatic send_bytes();
        foreach (img[i]) begin
            repeat ($urandom_range(0, 2)) begin
                rand_core();
                tick();
            end
            rand_core();
            rx_valid = 1'b1;
            rx_data  = img[i];
            tick();
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
        end
    endtask

    task automatic run_image(input string tag);
        int loaded;
        model_image(loaded);
        obs_q.delete();
        send_bytes();
        check($sformatf("%s_hold_rst", tag), 64'(core_rstn), 64'd0);
        check($sformatf("%s_hold_load", tag), 64'(loading), 64'd1);
        tick();
        check($sformatf("%s_release", tag), 64'(core_rstn), 64'd1);
        check($sformatf("%s_running", tag), 64'(loading), 64'd0);
        check($sformatf("%s_nwrites", tag), 64'(obs_q.size()), 64'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < obs_q.size())
                check($sformatf("%s_wr%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
        end
        check($sformatf("%s_loaded", tag), 64'(loaded_words), 64'(loaded));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rstn       = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        reload     = 1'b0;
        core_memwe = 1'b1;
        core_memaddr = 8'h5A;
        core_memdin  = 32'hFFFF_FFFF;

        // Reset state, with the core trying to write.
        repeat (3) tick();
        check("rst_memwe", 64'(memwe), 64'd0);
        check("rst_memaddr", 64'(memaddr), 64'd0);
        check("rst_memdin", 64'(memdin), 64'd0);
        check("rst_core_rstn", 64'(core_rstn), 64'd0);
        check("rst_loading", 64'(loading), 64'd1);
        check("rst_loaded", 64'(loaded_words), 64'd0);
        rstn = 1'b1;
        tick();

        // Two-word image with literal expectations.
        begin_image(2);
        add_word(32'h1234_5678);
        add_word(32'hDEAD_BEEF);
        run_image("two");
        check("two_w0", 64'(obs_q[0]), 64'({8'h00, 32'h1234_5678}));
        check("two_w1", 64'(obs_q[1]), 64'({8'h01, 32'hDEAD_BEEF}));
        check("two_loaded_lit", 64'(loaded_words), 64'd2);

        // Empty image.
        reload = 1'b1;
        tick();
        reload = 1'b0;
        begin_image(0);
        run_image("empty");

        // Core passthrough in S_RUN, zero-cycle.
        core_memwe   = 1'b1;
        core_memaddr = 8'h40;
        core_memdin  = 32'h0000_00A5;
        #1;
        check("pass_we", 64'(memwe), 64'd1);
        check("pass_addr", 64'(memaddr), 64'h40);
        check("pass_din", 64'(memdin), 64'hA5);
        for (int i = 0; i < 6; i++) begin
            rand_core();
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            #1;
            check("pass_rnd_we", 64'(memwe), 64'(core_memwe));
            check("pass_rnd_addr", 64'(memaddr), 64'(core_memaddr));
            check("pass_rnd_din", 64'(memdin), 64'(core_memdin));
            tick();
            check("run_ignores_rx", 64'(loading), 64'd0);
        end
        rx_valid = 1'b0;

        // Reload from S_RUN.
        reload = 1'b1;
        tick();
        reload = 1'b0;
        check("reload_core_rstn", 64'(core_rstn), 64'd0);
        check("reload_loading", 64'(loading), 64'd1);
        check("reload_loaded", 64'(loaded_words), 64'd0);

        // Overflow image: 257 words, only the first DEPTH are written.
        begin_image(257);
        for (int w = 0; w < 257; w++) add_word($urandom);
        run_image("ovf");
        check("ovf_last_addr", 64'(obs_q[obs_q.size()-1] >> 32), 64'd255);

        // Reload mid S_DATA together with a byte: the byte must be dropped.
        reload = 1'b1;
        tick();
        reload = 1'b0;
        obs_q.delete();
        begin_image(1);
        img.push_back(8'hAA);
        img.push_back(8'hBB);
        send_bytes();
        rx_valid = 1'b1;
        rx_data  = 8'hCC;
        reload   = 1'b1;
        tick();
        rx_valid = 1'b0;
        reload   = 1'b0;
        check("abort_loading", 64'(loading), 64'd1);
        check("abort_loaded", 64'(loaded_words), 64'd0);
        check("abort_nwrites", 64'(obs_q.size()), 64'd0);
        begin_image(1);
        add_word(32'h1122_3344);
        run_image("fresh");
        check("fresh_w0", 64'(obs_q[0]), 64'({8'h00, 32'h1122_3344}));

        // Reset in the middle of a load after one word and a stray byte.
        reload = 1'b1;
        tick();
        reload = 1'b0;
        begin_image(3);
        add_word($urandom);
        img.push_back(8'($urandom));
        send_bytes();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("midrst_loading", 64'(loading), 64'd1);
        check("midrst_core_rstn", 64'(core_rstn), 64'd0);
        check("midrst_loaded", 64'(loaded_words), 64'd0);

        // Random images.
        for (int k = 0; k < 5; k++) begin
            begin_image($urandom_range(1, 8));
            for (int w = 0; w < int'({img[1], img[0]}); w++) add_word($urandom);
            run_image($sformatf("rnd%0d", k));
            reload = 1'b1;
            tick();
            reload = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
